// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store controller with read-modify-write sub-word stores
module mem_access_ctrl #(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_dout,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR     = 3'd1;
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] RMW_WR = 3'd3;
    localparam logic [2:0] LD     = 3'd4;

    logic [2:0]  state;
    logic [31:0] addr_q, wdata_q, pc_q, merge_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        bad_align, out_of_range, req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] merged, load_val;

    always_comb begin
        bad_align = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        out_of_range = (req_addr[31:12] != 20'd0)
                    || ({22'd0, req_addr[11:2]} >= 32'(DM_WORDS));
        req_err = bad_align || out_of_range;
    end

    // Sub-word store: replace only the addressed lane(s) of the word captured in RMW_RD.
    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = dm_dout[7:0];
            2'd1:    lane_b = dm_dout[15:8];
            2'd2:    lane_b = dm_dout[23:16];
            default: lane_b = dm_dout[31:24];
        endcase
        lane_h = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sign_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{sign_q & lane_h[15]}}, lane_h};
            default: load_val = dm_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            merge_q     <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_err) begin
                            err <= 1'b1;
                        end else begin
                            addr_q  <= req_addr;
                            wdata_q <= req_wdata;
                            pc_q    <= req_pc;
                            size_q  <= req_size;
                            sign_q  <= req_sign;
                            if (!req_we)                 state <= LD;
                            else if (req_size == 2'b10)  state <= WR;
                            else                         state <= RMW_RD;
                        end
                    end
                end
                WR:     state <= IDLE;
                RMW_RD: begin
                    merge_q <= dm_dout;
                    state   <= RMW_WR;
                end
                RMW_WR: state <= IDLE;
                LD: begin
                    rdata       <= load_val;
                    rdata_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write strobe is gated by reset so an abandoned store never reaches memory.
    always_comb begin
        req_ready = (state == IDLE);
        dm_we     = !reset && (state == WR || state == RMW_WR);
        dm_addr   = (state == IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
        dm_din    = 32'd0;
        if (dm_we) dm_din = (state == WR) ? wdata_q : merged;
        dm_pc     = dm_we ? pc_q : 32'd0;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: DM_WORDS, 1024, data-memory depth in 32-bit words; word index = addr[11:2].
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req_valid in 1; req_we in 1 (1=store); req_size in 2 (00 byte, 01 half, 10 word, 11 illegal); req_sign in 1 (load sign-extend); req_addr in 32; req_wdata in 32; req_pc in 32 (store logging tag).
REQ-005 SHALL have port: req_ready  out  1  request accepted on a cycle with req_valid & req_ready.
REQ-006 SHALL have ports to data memory: dm_we out 1; dm_addr out 32; dm_din out 32; dm_pc out 32; dm_dout in 32 (combinational read of word at dm_addr).
REQ-007 SHALL have ports: rdata out 32; rdata_valid out 1; err out 1 (misaligned/illegal/out-of-range request).

Function
REQ-008 SHALL implement states IDLE, WR, RMW_RD, RMW_WR, LD; req_ready = (state==IDLE).
REQ-009 SHALL check on acceptance: size 11, half with addr[0]=1, or word with addr[1:0]!=00 -> misaligned/illegal.
REQ-010 SHALL treat an accepted request with any addr bit above bit 11 set, or addr[11:2] >= DM_WORDS, as out-of-range.
REQ-011 SHALL, for an errored request, perform no DM access, stay in IDLE, and pulse err=1 for exactly the following cycle.
REQ-012 SHALL latch addr, size, sign, wdata, pc on acceptance; later req_* changes have no effect until back in IDLE.
REQ-013 SHALL drive dm_addr = {latched addr[31:2],2'b00} in WR, RMW_RD, RMW_WR, LD, and 0 in IDLE.
REQ-014 SHALL use little-endian lanes: byte k = bits [8k+7:8k], k = addr[1:0]; half at addr[1]=0 -> bits 15:0, addr[1]=1 -> bits 31:16.
REQ-015 SHALL, for a word store, go IDLE->WR; in WR dm_we=1, dm_din=wdata; then IDLE (2 cycles total including acceptance).
REQ-016 SHALL, for byte/half stores, go IDLE->RMW_RD (capture dm_dout into merge register) ->RMW_WR (dm_we=1, dm_din = captured word with only the target lane(s) replaced by wdata[7:0]/wdata[15:0]) ->IDLE.
REQ-017 SHALL, for loads, go IDLE->LD; in LD capture the selected lane from dm_dout, zero- or sign-extended per latched sign (word: unchanged); next cycle rdata_valid=1 for one cycle with rdata holding the value.
REQ-018 SHALL hold rdata until the next load completes or reset; rdata_valid and err are one-cycle pulses.
REQ-019 SHALL assert dm_we only in WR and RMW_WR, never more than once per accepted store.
REQ-020 SHALL drive dm_pc = latched pc whenever dm_we=1, else 0.
REQ-021 SHALL not accept a new request in the cycle rdata_valid or err pulses unless state==IDLE (it always is, so back-to-back requests are allowed).

Reset
REQ-022 SHALL, on reset, go to IDLE and drive dm_we=0, dm_addr=0, dm_din=0, dm_pc=0, rdata=0, rdata_valid=0, err=0, req_ready=1 the following cycle.
REQ-023 SHALL, on reset asserted in RMW_RD, RMW_WR, WR or LD, abandon the operation: no dm_we that cycle, no rdata_valid or err afterwards.
REQ-024 SHALL give reset priority over a same-cycle req_valid; that request is dropped.

Verification
REQ-025 SHALL pass: word store addr 0x10, data 0xDEADBEEF -> next cycle dm_we=1, dm_addr=0x10, dm_din=0xDEADBEEF; req_ready low that cycle only.
REQ-026 SHALL pass: mem[0x10]=0xDEADBEEF, sb addr 0x12 data 0x55 -> RMW_RD then dm_we=1 with dm_din=0xDE55BEEF; exactly one write.
REQ-027 SHALL pass: mem[0x20]=0x80F07F01, lb signed addr 0x21 -> rdata=0x0000007F; lb signed 0x23 -> 0xFFFFFF80; lhu 0x22 -> 0x000080F0; lh 0x22 -> 0xFFFF80F0.
REQ-028 SHALL pass: sw addr 0x06, sh addr 0x03, size 11, and sw addr 0x1000 -> err pulses once each, dm_we never asserted, req_ready stays 1.
REQ-029 SHALL pass: sh addr 0x20 accepted, reset asserted during RMW_WR cycle -> dm_we=0, mem[0x20] unchanged, outputs all zero after reset.
REQ-030 SHALL pass: back-to-back sw 0x0, lw 0x0 -> lw accepted on the cycle after the write, rdata_valid two cycles later with the stored value.
